// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - boxhead game-state sequencer: title, play, death, game-over overlay, restart
module game_flow_ctrl #(
    parameter int         DYING_FRAMES    = 60,
    parameter int         BLINK_HALF      = 30,
    parameter int         MIN_SHOW_FRAMES = 120,
    parameter logic [7:0] RESTART_KEY     = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       player_dead,
    input  logic [7:0] keycode,
    output logic       game_over_on,
    output logic       game_active,
    output logic       game_reset,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_DYING = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [7:0] L_DYING = DYING_FRAMES[7:0];
    localparam logic [7:0] L_BLINK = BLINK_HALF[7:0];
    localparam logic [7:0] L_SHOW  = MIN_SHOW_FRAMES[7:0];

    logic [2:0] r_state;
    logic       r_frame_q;
    logic       r_key_up;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_blink_cnt;
    logic       r_over_on;
    logic       r_active;
    logic       r_reset;

    logic       w_frame_tick;
    logic       w_key_hit;
    logic [7:0] w_frame_inc;
    logic [7:0] w_blink_inc;
    logic       w_blink_done;
    logic       w_entering;
    logic [2:0] w_next_state;
    logic [7:0] w_frame_cnt_d;
    logic [7:0] w_blink_cnt_d;
    logic       w_over_on_d;
    logic       w_active_d;
    logic       w_reset_d;

    // r_key_up clears on reset so a key held across reset release is not a fresh press
    assign w_frame_tick = frame_clk & ~r_frame_q;
    assign w_key_hit    = (keycode == RESTART_KEY) & r_key_up;
    assign w_frame_inc  = r_frame_cnt + 8'd1;
    assign w_blink_inc  = r_blink_cnt + 8'd1;
    assign w_blink_done = w_frame_tick & (w_blink_inc == L_BLINK);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_frame_q   <= 1'b0;
            r_key_up    <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_blink_cnt <= 8'd0;
            r_over_on   <= 1'b0;
            r_active    <= 1'b0;
            r_reset     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_frame_q   <= frame_clk;
            r_key_up    <= (keycode != RESTART_KEY);
            r_frame_cnt <= w_frame_cnt_d;
            r_blink_cnt <= w_blink_cnt_d;
            r_over_on   <= w_over_on_d;
            r_active    <= w_active_d;
            r_reset     <= w_reset_d;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_key_hit) w_next_state = S_START;
            S_START: w_next_state = S_PLAY;
            S_PLAY:  if (player_dead) w_next_state = S_DYING;
            S_DYING: if (w_frame_tick && (w_frame_inc == L_DYING)) w_next_state = S_OVER;
            S_OVER:  if (w_key_hit && (r_frame_cnt == L_SHOW)) w_next_state = S_START;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Counters clear on every state entry; a tick on the entry edge is dropped
    always_comb begin
        w_entering    = (w_next_state != r_state);
        w_frame_cnt_d = r_frame_cnt;
        w_blink_cnt_d = r_blink_cnt;
        w_over_on_d   = r_over_on;
        if (w_entering) begin
            w_frame_cnt_d = 8'd0;
            w_blink_cnt_d = 8'd0;
        end else if (w_frame_tick) begin
            if (r_state == S_DYING || (r_state == S_OVER && r_frame_cnt != L_SHOW))
                w_frame_cnt_d = w_frame_inc;
            if (r_state == S_OVER)
                w_blink_cnt_d = w_blink_done ? 8'd0 : w_blink_inc;
        end
        if (w_next_state != S_OVER)
            w_over_on_d = 1'b0;
        else if (w_entering)
            w_over_on_d = 1'b1;
        else if (w_blink_done)
            w_over_on_d = ~r_over_on;
        w_active_d = (w_next_state == S_PLAY);
        w_reset_d  = (w_next_state == S_START);
    end

    assign state        = r_state;
    assign game_over_on = r_over_on;
    assign game_active  = r_active;
    assign game_reset   = r_reset;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed and randomized bench for game_flow_ctrl against a tick-count model
module tb_game_flow_ctrl;

    localparam int         D   = 3;
    localparam int         BH  = 2;
    localparam int         MS  = 5;
    localparam logic [7:0] KEY = 8'h28;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       player_dead = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       game_over_on;
    logic       game_active;
    logic       game_reset;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase (0..4) plus frames seen since entering it; blink and gates derive from that count
    int m_st = 0;
    int m_ticks = 0;
    bit m_fprev = 1'b0;
    bit m_kup = 1'b0;

    game_flow_ctrl #(
        .DYING_FRAMES(D), .BLINK_HALF(BH), .MIN_SHOW_FRAMES(MS), .RESTART_KEY(KEY)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .player_dead(player_dead),
        .keycode(keycode), .game_over_on(game_over_on), .game_active(game_active),
        .game_reset(game_reset), .state(state)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit tick, hit;
        int nst;
        if (Reset) begin
            m_st = 0; m_ticks = 0; m_fprev = 1'b0; m_kup = 1'b0;
            return;
        end
        tick = frame_clk && !m_fprev;
        hit  = (keycode == KEY) && m_kup;
        nst  = m_st;
        case (m_st)
            0: if (hit) nst = 1;
            1: nst = 2;
            2: if (player_dead) nst = 3;
            3: if (tick && m_ticks + 1 == D) nst = 4;
            4: if (hit && m_ticks >= MS) nst = 1;
            default: nst = 0;
        endcase
        if (nst != m_st) m_ticks = 0;
        else if (tick && (m_st == 3 || m_st == 4)) m_ticks++;
        m_st    = nst;
        m_fprev = frame_clk;
        m_kup   = (keycode != KEY);
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
        chk("state", int'(state), m_st);
        chk("game_active", int'(game_active), int'(m_st == 2));
        chk("game_reset", int'(game_reset), int'(m_st == 1));
        chk("game_over_on", int'(game_over_on), int'(m_st == 4 && ((m_ticks / BH) % 2 == 0)));
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1; step(); step();
        frame_clk = 1'b0; step(); step(); step();
    endtask

    int blink_seq [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};

    initial begin
        int fcnt;
        #1;
        // Reset with the restart key held through release
        Reset = 1'b1; keycode = KEY;
        step(); step();
        chk("rst_state", int'(state), 0);
        chk("rst_over", int'(game_over_on), 0);
        Reset = 1'b0;
        step(); step(); step();
        chk("held_key_no_start", int'(state), 0);
        keycode = 8'h00; step();
        keycode = KEY; step();
        chk("start_state", int'(state), 1);
        chk("start_pulse", int'(game_reset), 1);
        step();
        chk("play_state", int'(state), 2);
        chk("play_active", int'(game_active), 1);
        step(); step(); step();
        chk("held_no_reset", int'(game_reset), 0);

        // Death and restart key on the same edge: death wins
        keycode = 8'h00; step();
        keycode = KEY; player_dead = 1'b1; step();
        chk("dead_over_key", int'(state), 3);
        player_dead = 1'b0; keycode = 8'h00;
        frame_pulse(); frame_pulse();
        chk("dying_hold", int'(state), 3);
        frame_pulse();
        chk("over_state", int'(state), 4);
        chk("over_on_entry", int'(game_over_on), 1);

        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("blink_%0d", k), int'(game_over_on), blink_seq[k-1]);
            if (k == 4) begin
                keycode = KEY; step();
                chk("early_key_ignored", int'(state), 4);
                keycode = 8'h00; step();
            end
            frame_pulse();
        end
        keycode = KEY; step();
        chk("restart_state", int'(state), 1);
        chk("restart_pulse", int'(game_reset), 1);
        step();
        chk("restart_play", int'(state), 2);
        chk("restart_over_off", int'(game_over_on), 0);
        keycode = 8'h00;

        // Reset while the overlay is lit
        player_dead = 1'b1; step(); player_dead = 1'b0;
        frame_pulse(); frame_pulse(); frame_pulse();
        chk("over_again", int'(game_over_on), 1);
        Reset = 1'b1; step();
        chk("rst_in_over_state", int'(state), 0);
        chk("rst_in_over_on", int'(game_over_on), 0);
        Reset = 1'b0; step();

        // Randomized traffic
        fcnt = 0;
        for (int i = 0; i < 5000; i++) begin
            Reset = ($urandom_range(0, 599) == 0);
            if (fcnt == 0) begin
                frame_clk = ~frame_clk;
                fcnt = $urandom_range(2, 6);
            end else begin
                fcnt--;
            end
            if ($urandom_range(0, 29) == 0) player_dead = ~player_dead;
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: keycode = 8'h00;
                    1: keycode = KEY;
                    2: keycode = KEY;
                    default: keycode = 8'h04;
                endcase
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game-state sequencer for the boxhead game: title → play → death → game-over → restart.
- Owns the enable of the "GAME OVER" overlay sprite generator and drives its blink timing.
- Issues a one-cycle reset pulse to the play-field objects (player, zombies, score) on every new game.
- Sits between the keyboard decoder, the player/collision logic and the overlay/colour-mapper path; all timing is counted in video frames.

Parameters:
- DYING_FRAMES, 60, frames between player death and the overlay appearing (1..255).
- BLINK_HALF, 30, frames per overlay on/off half-period (1..255).
- MIN_SHOW_FRAMES, 120, frames in OVER before a restart key is accepted (1..255).
- RESTART_KEY, 8'h28, keycode that starts or restarts a game (Enter).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  frame-rate strobe (vsync level); only its rising edge is used.
- player_dead  in  1  level, high while the player's health is zero.
- keycode  in  8  current keyboard keycode; 8'h00 = none.
- game_over_on  out  1  overlay enable to the game-over sprite generator.
- game_active  out  1  high only in PLAY; gates player/enemy movement.
- game_reset  out  1  one-cycle pulse clearing play-field objects.
- state  out  3  encoded FSM state for debug/HEX display.

Behaviour:
- One clock, synchronous active-high Reset; all outputs registered.
- Reset → state=IDLE, game_over_on=0, game_active=0, game_reset=0, all counters 0, edge-detect registers 0.
- Reset asserted mid-operation (any state) returns to IDLE on the next edge; no game_reset pulse is produced by Reset itself.
- frame_tick = frame_clk & ~frame_clk_q. This is a one-cycle pulse the cycle after the rising edge is sampled.
- key_hit = (keycode==RESTART_KEY) & ~(keycode_q==RESTART_KEY). Holding the key produces exactly one key_hit. A key already held when a state is entered does not count.
- State encoding: IDLE=0, START=1, PLAY=2, DYING=3, OVER=4; values 5-7 are unreachable and recover to IDLE.
- IDLE: key_hit → START.
- START: exactly one cycle long; game_reset=1 in this cycle only, then → PLAY.
- PLAY: game_active=1. player_dead → DYING. player_dead has priority over a simultaneous key_hit; key_hit in PLAY is ignored.
- DYING: frame_cnt increments on frame_tick. When frame_cnt reaches DYING_FRAMES → OVER. game_over_on=0 throughout.
- OVER:
  - game_over_on=1 on entry and toggles each time blink_cnt reaches BLINK_HALF (blink_cnt then clears).
  - frame_cnt saturates at MIN_SHOW_FRAMES.
  - key_hit with frame_cnt==MIN_SHOW_FRAMES → START. Earlier key_hits are discarded, not queued.
  - player_dead is ignored.
- Leaving OVER clears game_over_on in the same edge as the transition.
- Counter rules:
  - frame_cnt and blink_cnt are 8 bits and clear on every state entry.
  - A frame_tick coinciding with the entry edge is not counted.
  - Comparisons are equality against the parameter; wrap-around cannot occur because of saturation or the state exit.
- Registered output timing: game_active and game_over_on change in the same cycle as state.

Test Plan:
- Reset held 2 cycles in arbitrary state, then released → state=0, all outputs 0; keycode held at 8'h28 through the release produces no start until released and re-pressed.
- IDLE, keycode 00→28 → state 1 for exactly one cycle with game_reset=1, then state 2 with game_active=1; holding 28 causes no further game_reset.
- Overrides DYING_FRAMES=3, BLINK_HALF=2, MIN_SHOW_FRAMES=5. In PLAY, player_dead=1 and key_hit in the same cycle → DYING, no START. After the 3rd frame_tick → OVER, game_over_on=1.
- In OVER with the above overrides, 10 frame_ticks → game_over_on sequence 1,1,0,0,1,1,0,0,1,1 (toggle after ticks 2,4,6,8).
- Key press after 3 ticks in OVER → ignored. Release and re-press after tick 5 → START pulse, then PLAY with game_over_on=0.
- Reset asserted in OVER with game_over_on=1 → next cycle state=IDLE, game_over_on=0, counters 0. Force state=7 → IDLE next cycle.
